// File: rtl/fetch_unit.sv
// fetch_unit: issues instruction-memory reads for the current PC and queues PC-tagged instructions for decode
// Ports: clk/rst (sync, active-high); pc in, pc_advance out (select pc+4); flush redirect;
//   imem_req/imem_addr out, imem_ack/imem_rdata in; instr_valid/instr/instr_pc out, instr_ready in;
//   fault out (sticky misaligned PC, cleared by flush or rst).
module fetch_unit #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready,
  output logic              fault
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, head, flush_ptr;
  logic [31:0] req_pc_q, req_pc_d;
  logic fault_q, fault_d;
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [31:0] tag_q [DEPTH];
  logic [31:0] tag_d [DEPTH];
  logic issue, push, pop, misalign;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      req_pc_q <= '0;
      fault_q  <= 1'b0;
      data_q   <= '{default: '0};
      tag_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      req_pc_q <= req_pc_d;
      fault_q  <= fault_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (issue ? WAIT : IDLE) :
              imem_ack ? IDLE :
              (state_q == WAIT && !flush) ? WAIT : DRAIN;
  end
  always_comb begin
    issue      = (state_q == IDLE) & ~rst & ~flush & ~fault_q & (pc[1:0] == 2'b00) & (count_q < CW'(DEPTH));
    imem_req   = issue;
    pc_advance = issue;
  end
  assign imem_addr   = pc[ADDR_W+1:2];
  assign misalign    = (state_q == IDLE) & ~flush & ~fault_q & (pc[1:0] != 2'b00);
  assign push        = (state_q == WAIT) & imem_ack & ~flush;
  assign instr_valid = count_q != '0;
  assign pop         = instr_valid & instr_ready & ~flush;
  assign fault       = fault_q;
  // When empty, show the slot just behind the read pointer so the last head stays visible.
  assign head        = instr_valid ? rd_q : rd_q - PW'(1);
  assign instr       = data_q[head];
  assign instr_pc    = tag_q[head];
  // A flush steps both pointers past the current head, keeping it as the held display value.
  assign flush_ptr   = rd_q + PW'(instr_valid);
  always_comb begin
    req_pc_d = issue ? pc : req_pc_q;
    fault_d  = flush ? 1'b0 : (fault_q | misalign);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d     = flush ? flush_ptr : (push ? wr_q + PW'(1) : wr_q);
    rd_d     = flush ? flush_ptr : (pop ? rd_q + PW'(1) : rd_q);
    data_d   = data_q;
    tag_d    = tag_q;
    if (push) begin
      data_d[wr_q] = imem_rdata;
      tag_d[wr_q]  = req_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, flush, imem_ack, instr_ready;
  logic [31:0] pc, imem_rdata;
  logic pc_advance, imem_req, instr_valid, fault;
  logic [9:0] imem_addr;
  logic [31:0] instr, instr_pc;
  logic [63:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.ADDR_W(10), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_advance(pc_advance), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && !flush && instr_valid && instr_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, required no entry", instr_pc, instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          n_err++;
          $display("FAIL pop_order: got pc=%h instr=%h, required pc=%h instr=%h", instr_pc, instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic do_ack(input logic [31:0] d, input logic [31:0] p);
    imem_ack = 1'b1;
    imem_rdata = d;
    exp_q.push_back({p, d});
    tick();
    imem_ack = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1; pc = 32'h0;
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_adv", {31'b0, pc_advance}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    rst = 1'b0;
    #1;
    // basic fetch
    chk("b_req1", {31'b0, imem_req}, 32'd1);
    chk("b_adv1", {31'b0, pc_advance}, 32'd1);
    chk("b_addr1", {22'b0, imem_addr}, 32'd0);
    tick();
    pc = 32'h4;
    #1;
    chk("b_wait_req", {31'b0, imem_req}, 32'd0);
    do_ack(32'h20010005, 32'h0);
    chk("b_valid", {31'b0, instr_valid}, 32'd1);
    chk("b_instr", instr, 32'h20010005);
    chk("b_instr_pc", instr_pc, 32'h0);
    chk("b_req2", {31'b0, imem_req}, 32'd1);
    chk("b_addr2", {22'b0, imem_addr}, 32'd1);
    tick();
    pc = 32'h8;
    do_ack(32'h00000013, 32'h4);
    chk("b_instr2", instr, 32'h00000013);
    chk("b_instr_pc2", instr_pc, 32'h4);
    // backpressure
    instr_ready = 1'b0;
    do_reset();
    pc = 32'h0;
    #1;
    tick();
    pc = 32'h4;
    do_ack(32'h11111111, 32'h0);
    chk("bp_req2", {31'b0, imem_req}, 32'd1);
    chk("bp_addr2", {22'b0, imem_addr}, 32'd1);
    tick();
    pc = 32'h8;
    do_ack(32'h22222222, 32'h4);
    chk("bp_full_req", {31'b0, imem_req}, 32'd0);
    chk("bp_full_adv", {31'b0, pc_advance}, 32'd0);
    tick();
    chk("bp_hold_req", {31'b0, imem_req}, 32'd0);
    chk("bp_head", instr, 32'h11111111);
    chk("bp_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    #1;
    chk("bp_pop_cycle_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("bp_after_pop_req", {31'b0, imem_req}, 32'd1);
    chk("bp_after_pop_addr", {22'b0, imem_addr}, 32'd2);
    chk("bp_head2_pc", instr_pc, 32'h4);
    // flush while waiting
    do_reset();
    pc = 32'h8;
    #1;
    chk("fw_req", {31'b0, imem_req}, 32'd1);
    tick();
    pc = 32'hC;
    flush = 1'b1;
    #1;
    chk("fw_flush_req", {31'b0, imem_req}, 32'd0);
    tick();
    flush = 1'b0;
    pc = 32'h40;
    #1;
    chk("fw_drain_req", {31'b0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    #1;
    chk("fw_ack_req", {31'b0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("fw_dropped", {31'b0, instr_valid}, 32'd0);
    chk("fw_req2", {31'b0, imem_req}, 32'd1);
    chk("fw_addr2", {22'b0, imem_addr}, 32'h10);
    // flush coincident with ack
    do_reset();
    pc = 32'h10;
    #1;
    tick();
    pc = 32'h14;
    imem_ack = 1'b1;
    imem_rdata = 32'h12345678;
    flush = 1'b1;
    #1;
    chk("fa_req", {31'b0, imem_req}, 32'd0);
    tick();
    imem_ack = 1'b0;
    flush = 1'b0;
    pc = 32'h80;
    #1;
    chk("fa_empty", {31'b0, instr_valid}, 32'd0);
    chk("fa_req2", {31'b0, imem_req}, 32'd1);
    chk("fa_addr2", {22'b0, imem_addr}, 32'h20);
    // misaligned
    do_reset();
    pc = 32'h6;
    #1;
    chk("ma_req", {31'b0, imem_req}, 32'd0);
    chk("ma_adv", {31'b0, pc_advance}, 32'd0);
    tick();
    chk("ma_fault", {31'b0, fault}, 32'd1);
    pc = 32'h8;
    #1;
    chk("ma_blocked", {31'b0, imem_req}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("ma_cleared", {31'b0, fault}, 32'd0);
    chk("ma_req2", {31'b0, imem_req}, 32'd1);
    chk("ma_addr2", {22'b0, imem_addr}, 32'd2);
    // reset mid-operation
    instr_ready = 1'b0;
    do_reset();
    pc = 32'h0;
    #1;
    tick();
    pc = 32'h4;
    do_ack(32'hAAAAAAAA, 32'h0);
    tick();
    pc = 32'h8;
    chk("rm_pre_valid", {31'b0, instr_valid}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    flush = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk("rm_valid", {31'b0, instr_valid}, 32'd0);
    chk("rm_instr", instr, 32'd0);
    chk("rm_instr_pc", instr_pc, 32'd0);
    chk("rm_fault", {31'b0, fault}, 32'd0);
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'hBADBAD00;
    tick();
    imem_ack = 1'b0;
    flush = 1'b0;
    #1;
    chk("rm_stray", {31'b0, instr_valid}, 32'd0);
    chk("rm_idle_req", {31'b0, imem_req}, 32'd1);
    tick();
    tick();
    chk("sb_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register. Takes the current PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions, tagged with their PC, in a small FIFO and hands them to decode over a valid/ready handshake.
- Drives pc_advance, which the next-PC mux uses to choose pc+4 or hold. Handles branch redirect (flush) and misaligned-PC faults.

Parameters:
- ADDR_W, 10, instruction-memory word-address width (imem_addr = pc[ADDR_W+1:2]).
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  current PC from the PC register.
- pc_advance  out  1  high in the cycle a fetch for pc issues; the next-PC mux selects pc+4, otherwise holds pc.
- flush  in  1  redirect; the PC register loads the target at this edge.
- imem_req  out  1  read request; memory samples imem_addr at the edge where req=1.
- imem_addr  out  ADDR_W  word address.
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid the same cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  FIFO head valid.
- instr  out  32  head instruction.
- instr_pc  out  32  head PC.
- instr_ready  in  1  decode accepts the head.
- fault  out  1  sticky misaligned-PC flag.

Behaviour:
- Reset, all applied at the rst edge: state IDLE, FIFO empty, fault=0.
  - Resulting outputs: instr_valid=0, instr=0, instr_pc=0.
  - Combinational outputs while rst=1: imem_req=0, pc_advance=0.
- rst mid-operation discards any outstanding request. Memory shares the same reset. An ack arriving in IDLE is always ignored.
- States:
  - IDLE: may issue a request.
  - WAIT: one request outstanding.
  - DRAIN: request outstanding but flushed; its data will be discarded.
- Issue rule (combinational): imem_req = pc_advance = (state==IDLE) & ~rst & ~flush & ~fault & (pc[1:0]==0) & (count < DEPTH).
  - imem_addr = pc[ADDR_W+1:2] at all times.
  - On an issue edge: latch req_pc=pc, go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_ack & ~flush: push {req_pc, imem_rdata}, go to IDLE. Space is guaranteed by the issue rule, so no overflow check is needed.
  - The earliest next issue is the cycle after the ack. Throughput is at most one instruction per 2 cycles; ack latency is at least 1 cycle after req.
- Flush, which has priority over push, pop and issue:
  - FIFO count goes to 0 at that edge.
  - From WAIT without ack: go to DRAIN.
  - From WAIT with ack in the same cycle: drop the data, go to IDLE.
  - From IDLE: stay IDLE.
  - fault is cleared.
  - No issue occurs in the flush cycle; the first issue uses the redirected pc on the following IDLE cycle.
- DRAIN:
  - No issue.
  - On imem_ack: discard, go to IDLE.
  - A flush in DRAIN stays in DRAIN.
- FIFO:
  - instr_valid = (count != 0); instr and instr_pc are the head entry (registered storage, combinational head select).
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle leaves count unchanged, including when count == DEPTH, since the pop frees space in the same edge.
  - Pointers wrap modulo DEPTH.
  - When empty, instr and instr_pc hold their last value; they read 0 after reset.
  - Ordering is strictly FIFO.
- Misalignment: in IDLE with ~flush, ~fault and pc[1:0]!=0, set fault=1 at the edge; no request issues.
  - fault blocks issue until a flush or rst.
  - The FIFO still drains normally while fault=1.
- 32-bit PCs carry no arithmetic here; the pc+4 computation lives in the next-PC mux.

Test Plan:
- Basic fetch: rst then pc=0x0, instr_ready=1, memory acks 1 cycle after req with 0x20010005. Required: imem_req=1 with addr 0 in cycle 1; instr_valid=1 with instr=0x20010005 and instr_pc=0x0 in cycle 3; next req at pc=0x4 in cycle 3.
- Backpressure: instr_ready=0, fetch 0x0 and 0x4. Required: count=2, then imem_req=0 and pc_advance=0 held. Raise ready: heads appear in order 0x0 then 0x4, and the next req issues one cycle after the first pop.
- Flush while waiting: req at pc=0x8, flush next cycle with target 0x40, ack 3 cycles later with 0xDEADBEEF. Required: state DRAIN, no instr_valid, data dropped; req with addr 0x10 the cycle after the ack.
- Flush coincident with ack: WAIT, and in the same cycle imem_ack=1 with 0x12345678 and flush=1. Required: nothing pushed, FIFO empty, IDLE next cycle, issue on the redirected pc the cycle after.
- Misaligned: pc=0x6 in IDLE. Required: fault=1 next cycle, imem_req stays 0. Then flush with pc=0x8: fault=0, req addr 0x2 follows.
- Reset mid-operation: rst=1 during WAIT with 1 FIFO entry. Required: next cycle instr_valid=0, instr=0, fault=0, state IDLE. A stray ack 2 cycles later is ignored and nothing is pushed.
